// File: rtl/vga_scanout.sv
// 640x480 VGA scanout from a 320x240, 6-bit framebuffer, with every source pixel doubled 2x2.
// Optional colour-bar generator enabled by defining SCANOUT_TESTPAT_EN (adds the test_mode input).
module vga_scanout #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic        clock,
   input  logic        resetn,
`ifdef SCANOUT_TESTPAT_EN
   input  logic        test_mode,
`endif
   output logic [16:0] mem_addr,
   output logic        mem_rden,
   input  logic [5:0]  mem_data,
   output logic [7:0]  VGA_R,
   output logic [7:0]  VGA_G,
   output logic [7:0]  VGA_B,
   output logic        VGA_HS,
   output logic        VGA_VS,
   output logic        VGA_BLANK_N,
   output logic        VGA_CLK,
   output logic        frame_tick
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);
   localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic        pix_en;
   logic [9:0]  h_count;
   logic [9:0]  v_count;
   logic        visible;
   logic        h_sync_zone;
   logic        v_sync_zone;
   logic [16:0] addr_next;
   logic        vis_p;
   logic        hs_p;
   logic        vs_p;
   logic [5:0]  pix_data;
   logic [5:0]  colour_src;

`ifdef SCANOUT_TESTPAT_EN
   logic        tm_p;
   logic [2:0]  bar_p;

   function automatic logic [2:0] bar_index(input logic [9:0] h);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (int'(h) >= i * 80) idx = 3'(i);
      end
      return idx;
   endfunction
`endif

   // y*320 + x as two shifts and an add.
   always_comb begin
      visible     = (h_count < H_VIS) && (v_count < V_VIS);
      h_sync_zone = (h_count >= HS_FIRST) && (h_count <= HS_LAST);
      v_sync_zone = (v_count >= VS_FIRST) && (v_count <= VS_LAST);
      addr_next   = {v_count[9:1], 8'd0} + {2'd0, v_count[9:1], 6'd0} + {8'd0, h_count[9:1]};
      colour_src  = pix_data;
`ifdef SCANOUT_TESTPAT_EN
      if (tm_p) colour_src = {{2{bar_p[2]}}, {2{bar_p[1]}}, {2{bar_p[0]}}};
`endif
   end

   // The read is issued on the half-period before the counters advance, the RAM word is
   // captured on the following half-period, and everything reaches the pins together one
   // pixel period after the counters that produced it.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         pix_en      <= 1'b0;
         h_count     <= '0;
         v_count     <= '0;
         mem_addr    <= '0;
         mem_rden    <= 1'b0;
         frame_tick  <= 1'b0;
         vis_p       <= 1'b0;
         hs_p        <= 1'b1;
         vs_p        <= 1'b1;
         pix_data    <= '0;
         VGA_R       <= '0;
         VGA_G       <= '0;
         VGA_B       <= '0;
         VGA_BLANK_N <= 1'b0;
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
`ifdef SCANOUT_TESTPAT_EN
         tm_p        <= 1'b0;
         bar_p       <= '0;
`endif
      end else begin
         pix_en     <= ~pix_en;
         frame_tick <= 1'b0;
         if (pix_en) begin
            mem_rden <= 1'b0;
            if (h_count == H_LAST) begin
               h_count <= '0;
               if (v_count == V_LAST) v_count <= '0;
               else                   v_count <= v_count + 10'd1;
               if (v_count == V_VIS_LAST) frame_tick <= 1'b1;
            end else begin
               h_count <= h_count + 10'd1;
            end
            vis_p <= visible;
            hs_p  <= ~h_sync_zone;
            vs_p  <= ~v_sync_zone;
`ifdef SCANOUT_TESTPAT_EN
            tm_p  <= test_mode;
            bar_p <= bar_index(h_count);
`endif
            VGA_BLANK_N <= vis_p;
            VGA_HS      <= hs_p;
            VGA_VS      <= vs_p;
            VGA_R       <= vis_p ? {4{colour_src[5:4]}} : 8'd0;
            VGA_G       <= vis_p ? {4{colour_src[3:2]}} : 8'd0;
            VGA_B       <= vis_p ? {4{colour_src[1:0]}} : 8'd0;
         end else begin
            mem_rden <= visible;
            if (visible) mem_addr <= addr_next;
            if (vis_p)   pix_data <= mem_data;
         end
      end
   end

   assign VGA_CLK = pix_en;

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout: a pixel-position model predicts the output stream and
// read addresses; a negedge monitor pops and compares while also timing syncs and frame ticks.
module tb_vga_scanout;

   localparam int HV  = 640;
   localparam int HF  = 16;
   localparam int HSY = 96;
   localparam int HB  = 48;
   localparam int VV  = 4;
   localparam int VF  = 1;
   localparam int VSY = 2;
   localparam int VB  = 1;
   localparam int HT  = HV + HF + HSY + HB;
   localparam int VT  = VV + VF + VSY + VB;
   localparam int FRAME_PIX = HT * VT;

   logic        clock = 1'b0;
   logic        resetn;
   logic [16:0] mem_addr;
   logic        mem_rden;
   logic [5:0]  mem_data;
   logic [7:0]  VGA_R, VGA_G, VGA_B;
   logic        VGA_HS, VGA_VS, VGA_BLANK_N, VGA_CLK, frame_tick;
`ifdef SCANOUT_TESTPAT_EN
   logic        test_mode;
`endif

   always #10 clock = ~clock;

   vga_scanout #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB)
   ) dut (
      .clock       (clock),
      .resetn      (resetn),
`ifdef SCANOUT_TESTPAT_EN
      .test_mode   (test_mode),
`endif
      .mem_addr    (mem_addr),
      .mem_rden    (mem_rden),
      .mem_data    (mem_data),
      .VGA_R       (VGA_R),
      .VGA_G       (VGA_G),
      .VGA_B       (VGA_B),
      .VGA_HS      (VGA_HS),
      .VGA_VS      (VGA_VS),
      .VGA_BLANK_N (VGA_BLANK_N),
      .VGA_CLK     (VGA_CLK),
      .frame_tick  (frame_tick)
   );

   // Framebuffer: valid data only on the clock after a read, noise otherwise.
   logic [5:0] fb [0:76799];
   always @(posedge clock) mem_data <= mem_rden ? fb[mem_addr] : 6'($urandom);

   logic [26:0] exp_q[$];
   logic [16:0] addr_q[$];
   int  tests = 0;
   int  fails = 0;
   int  cyc = 0;
   int  target;
   bit  tm = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit pix_visible(input int n);
      int h, v;
      h = n % HT;
      v = (n / HT) % VT;
      return (h < HV) && (v < VV);
   endfunction

   function automatic logic [26:0] model_pixel(input int n);
      int h, v, bar;
      logic vis, hs, vs;
      logic [5:0] c;
      logic [7:0] r, g, b;
      h   = n % HT;
      v   = (n / HT) % VT;
      vis = (h < HV) && (v < VV);
      hs  = !((h >= HV + HF) && (h < HV + HF + HSY));
      vs  = !((v >= VV + VF) && (v < VV + VF + VSY));
      c   = 6'd0;
      if (vis) begin
         if (tm) begin
            bar = h / 80;
            c = {((bar >> 2) & 1) != 0 ? 2'b11 : 2'b00,
                 ((bar >> 1) & 1) != 0 ? 2'b11 : 2'b00,
                 (bar & 1) != 0        ? 2'b11 : 2'b00};
         end else begin
            c = fb[(v / 2) * 320 + h / 2];
         end
      end
      r = 8'(85 * int'(c[5:4]));
      g = 8'(85 * int'(c[3:2]));
      b = 8'(85 * int'(c[1:0]));
      return {vis, hs, vs, r, g, b};
   endfunction

   // Two idle pixel periods precede pixel 0 at the pins.
   task automatic start_segment(input int npix);
      int h, v;
      repeat (2) exp_q.push_back({1'b0, 1'b1, 1'b1, 24'h0});
      for (int n = 0; n < npix; n++) begin
         exp_q.push_back(model_pixel(n));
         h = n % HT;
         v = (n / HT) % VT;
         if (pix_visible(n)) addr_q.push_back(17'((v / 2) * 320 + h / 2));
      end
   endtask

   int  hs_fall, vs_fall, tick_last;
   bit  hs_prev, vs_prev, exp_rden, exp_tick;
   logic [26:0] exp_v;
   logic [16:0] exp_a;

   always @(negedge clock) begin
      if (!resetn) begin
         cyc = 0; hs_fall = -1; vs_fall = -1; tick_last = -1;
         hs_prev = 1'b1; vs_prev = 1'b1;
         check("reset_out",
               32'({VGA_R, VGA_G, VGA_B, VGA_BLANK_N, VGA_HS, VGA_VS, VGA_CLK, mem_rden, frame_tick}),
               32'({24'h0, 6'b011000}));
      end else begin
         cyc++;
         exp_rden = (cyc % 2 == 0) && pix_visible((cyc - 2) / 2);
         check("pix_phase", 32'(VGA_CLK), 32'(cyc % 2 == 0));
         check("mem_rden", 32'(mem_rden), 32'(exp_rden));
         if (mem_rden && addr_q.size() > 0) begin
            exp_a = addr_q.pop_front();
            check("mem_addr", 32'(mem_addr), 32'(exp_a));
         end
         if (cyc % 2 == 1 && exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            check("vga_out", 32'({VGA_BLANK_N, VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B}), 32'(exp_v));
         end
         exp_tick = (cyc % 2 == 1) && ((cyc - 1) % (2 * FRAME_PIX) == 2 * VV * HT);
         if (exp_tick || frame_tick) check("frame_tick", 32'(frame_tick), 32'(exp_tick));
         if (frame_tick) begin
            if (tick_last >= 0) check("tick_period", 32'(cyc - tick_last), 32'(2 * FRAME_PIX));
            tick_last = cyc;
         end
         if (hs_prev && !VGA_HS) begin
            if (hs_fall >= 0) check("hs_period", 32'(cyc - hs_fall), 32'(2 * HT));
            hs_fall = cyc;
         end
         if (!hs_prev && VGA_HS && hs_fall >= 0) check("hs_low", 32'(cyc - hs_fall), 32'(2 * HSY));
         if (vs_prev && !VGA_VS) begin
            if (vs_fall >= 0) check("vs_period", 32'(cyc - vs_fall), 32'(2 * FRAME_PIX));
            vs_fall = cyc;
         end
         if (!vs_prev && VGA_VS && vs_fall >= 0) check("vs_low", 32'(cyc - vs_fall), 32'(2 * VSY * HT));
         hs_prev = VGA_HS;
         vs_prev = VGA_VS;
      end
   end

   initial begin
      resetn = 1'b0;
`ifdef SCANOUT_TESTPAT_EN
      test_mode = 1'b0;
`endif
      for (int i = 0; i < 76800; i++) fb[i] = 6'($urandom);
      fb[639] = 6'h3F;
      repeat (4) @(posedge clock);
      #2 resetn = 1'b1;
      start_segment(FRAME_PIX + 3 * HT + 400);

      // Run into the second frame and reset at h=300, v=3.
      target = 2 * (FRAME_PIX + 3 * HT + 300) + 1;
      for (int i = 0; i < 20000 && cyc < target; i++) @(posedge clock);
      check("seg1_reach", 32'(cyc >= target), 32'd1);
      #2 resetn = 1'b0;
      exp_q.delete();
      addr_q.delete();
      #1 check("reset_async",
               32'({VGA_R, VGA_G, VGA_B, VGA_BLANK_N, VGA_HS, VGA_VS, VGA_CLK, mem_rden, frame_tick}),
               32'({24'h0, 6'b011000}));
`ifdef SCANOUT_TESTPAT_EN
      tm = 1'b1;
      test_mode = 1'b1;
`endif
      repeat (3) @(posedge clock);
      #2 resetn = 1'b1;
      start_segment(2 * FRAME_PIX + 200);
      for (int i = 0; i < 27000 && exp_q.size() > 0; i++) @(posedge clock);
      check("seg2_drain", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
